// File: rtl/conv3_frame_streamer.sv
// ---------------------------------------------------------------------------
// conv3_frame_streamer
//
// Holds one WIDTH x HEIGHT feature map in an internal frame memory and, on a
// start pulse, transmits it in raster order as a valid/ready pixel stream
// suitable for the 3x3 convolution line buffer.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_en      frame-memory write strobe (honoured in IDLE only)
//   wr_addr    raster address row*WIDTH+col
//   wr_data    pixel to store
//   wr_err     one-cycle pulse when a write is dropped
//   start      begin streaming the frame (sampled in IDLE)
//   abort      cancel the stream in progress
//   ready_in   downstream can accept a pixel
//   valid_out  data_out is valid
//   data_out   current pixel
//   sol/eol    data_out is column 0 / column WIDTH-1
//   eof        data_out is the last pixel of the frame
//   busy       streaming in progress
//   done       one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module conv3_frame_streamer #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 10,
    parameter int DATA_BITS = 32,
    localparam int NPIX      = WIDTH * HEIGHT,
    localparam int ADDR_BITS = $clog2(NPIX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_err,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 sol,
    output logic                 eol,
    output logic                 eof,
    output logic                 busy,
    output logic                 done
);

    // One extra pointer bit so the read pointer can sit at NPIX after the
    // final pixel has been loaded into the output register.
    localparam int PTR_BITS = ADDR_BITS + 1;
    localparam int COL_BITS = $clog2(WIDTH);

    localparam logic [PTR_BITS-1:0] NPIX_P    = PTR_BITS'(NPIX);
    localparam logic [PTR_BITS-1:0] LAST_P    = PTR_BITS'(NPIX - 1);
    localparam logic [PTR_BITS-1:0] PTR_ZERO  = {PTR_BITS{1'b0}};
    localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
    localparam logic [COL_BITS-1:0] COL_ZERO  = {COL_BITS{1'b0}};
    localparam logic [COL_BITS-1:0] COL_ONE   = COL_BITS'(1);
    localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(WIDTH - 1);
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DATA_BITS-1:0]   mem_r [NPIX];
    logic [PTR_BITS-1:0]    rd_ptr_r;
    logic [COL_BITS-1:0]    col_r;
    logic                   valid_out_r;
    logic [DATA_BITS-1:0]   data_out_r;
    logic                   sol_r;
    logic                   eol_r;
    logic                   eof_r;
    logic                   done_r;
    logic                   wr_err_r;

    logic                   streaming_s;
    logic                   transfer_s;
    logic                   abort_s;
    logic                   finish_s;
    logic                   load_s;
    logic                   wr_ok_s;
    logic                   wr_bad_s;

    // Handshake, load and write-qualification decode.
    always_comb begin
        streaming_s = (state_r == ST_STREAM);
        transfer_s  = valid_out_r & ready_in;
        abort_s     = streaming_s & abort;
        // Abort wins over completion: an aborted frame never reports done.
        finish_s    = streaming_s & transfer_s & eof_r & ~abort;
        load_s      = streaming_s & ~abort & (rd_ptr_r < NPIX_P) &
                      (~valid_out_r | ready_in);
        wr_ok_s     = wr_en & ~streaming_s & ({1'b0, wr_addr} < NPIX_P);
        wr_bad_s    = wr_en & ~wr_ok_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (abort || finish_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame memory write port; contents are deliberately not reset.  A write
    // in the same cycle as start lands before the first read one edge later.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Dropped-write indication, one cycle after the offending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_bad_s;
        end
    end

    // Output register stage, read pointer, column counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= PTR_ZERO;
            col_r       <= COL_ZERO;
            valid_out_r <= 1'b0;
            data_out_r  <= DATA_ZERO;
            sol_r       <= 1'b0;
            eol_r       <= 1'b0;
            eof_r       <= 1'b0;
            done_r      <= 1'b0;
        end else if (abort_s || finish_s) begin
            rd_ptr_r    <= PTR_ZERO;
            col_r       <= COL_ZERO;
            valid_out_r <= 1'b0;
            sol_r       <= 1'b0;
            eol_r       <= 1'b0;
            eof_r       <= 1'b0;
            done_r      <= finish_s;
        end else if (load_s) begin
            data_out_r  <= mem_r[rd_ptr_r[ADDR_BITS-1:0]];
            sol_r       <= (col_r == COL_ZERO);
            eol_r       <= (col_r == COL_LAST);
            eof_r       <= (rd_ptr_r == LAST_P);
            valid_out_r <= 1'b1;
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            col_r       <= (col_r == COL_LAST) ? COL_ZERO : (col_r + COL_ONE);
            done_r      <= 1'b0;
        end else if (transfer_s) begin
            // Accepted with nothing left to load: drop valid cleanly.
            valid_out_r <= 1'b0;
            sol_r       <= 1'b0;
            eol_r       <= 1'b0;
            eof_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r      <= 1'b0;
        end
    end

    assign wr_err    = wr_err_r;
    assign valid_out = valid_out_r;
    assign data_out  = data_out_r;
    assign sol       = sol_r;
    assign eol       = eol_r;
    assign eof       = eof_r;
    assign busy      = (state_r == ST_STREAM);
    assign done      = done_r;

endmodule

// File: tb/tb_conv3_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_conv3_frame_streamer
//
// Directed bench for conv3_frame_streamer with default parameters (8x10x32).
// A write-port vector table covers accepted and dropped writes; hand-written
// sequences cover full frames, stalls, same-cycle start/write, abort and
// mid-stream reset.
// ---------------------------------------------------------------------------
module tb_conv3_frame_streamer;

    localparam int W    = 8;
    localparam int H    = 10;
    localparam int NPIX = W * H;
    localparam int AB   = 7;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_err;
    logic          start;
    logic          abort;
    logic          ready_in;
    logic          valid_out;
    logic [31:0]   data_out;
    logic          sol;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          done;

    int total;
    int bad;

    logic [31:0] exp_mem [NPIX];

    typedef struct {
        logic [AB-1:0] addr;
        logic [31:0]   data;
        logic          in_stream;
        logic          exp_err;
    } wr_vec_t;

    wr_vec_t wv [5];

    conv3_frame_streamer #(
        .WIDTH(W),
        .HEIGHT(H),
        .DATA_BITS(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_err(wr_err),
        .start(start),
        .abort(abort),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .sol(sol),
        .eol(eol),
        .eof(eof),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endfunction

    task automatic do_write(input int addr, input logic [31:0] data);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = AB'(addr);
        wr_data = data;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Start a frame and check pixels until n_xfer transfers have been
    // committed; returns just after the edge of the last transfer.
    task automatic stream_check(input int mode, input int n_xfer, input bit wr0,
                                input logic [31:0] wr0_data, input bit chk_span);
        int idx;
        int cyc;
        int first_cyc;
        int last_cyc;
        int early_done;
        bit stalled;
        logic [31:0] prev_d;
        logic [2:0]  prev_f;
        idx = 0; first_cyc = -1; last_cyc = -1; early_done = 0; stalled = 1'b0;
        prev_d = 32'd0; prev_f = 3'd0;
        @(posedge clk); #1;
        start = 1'b1;
        if (wr0) begin
            wr_en   = 1'b1;
            wr_addr = {AB{1'b0}};
            wr_data = wr0_data;
            exp_mem[0] = wr0_data;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        cyc = 0;
        while (idx < n_xfer && cyc < 2000) begin
            ready_in = ready_pat(mode, cyc);
            @(negedge clk);
            if (done) early_done++;
            if (first_cyc < 0 && valid_out) first_cyc = cyc;
            if (first_cyc >= 0) begin
                check("valid_held", {31'd0, valid_out}, 32'd1);
                check("busy", {31'd0, busy}, 32'd1);
                if (stalled) begin
                    check("stall_data", data_out, prev_d);
                    check("stall_flags", {29'd0, sol, eol, eof}, {29'd0, prev_f});
                end
                check("data", data_out, exp_mem[idx]);
                check("flags", {29'd0, sol, eol, eof},
                      {29'd0, (idx % W) == 0, (idx % W) == W - 1, idx == NPIX - 1});
                prev_d  = data_out;
                prev_f  = {sol, eol, eof};
                stalled = !ready_in;
                if (ready_in) begin
                    idx++;
                    last_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("xfer_count", idx, n_xfer);
        check("first_valid_latency", first_cyc, 1);
        check("no_early_done", early_done, 0);
        if (chk_span) check("frame_span", last_cyc - first_cyc + 1, NPIX);
    endtask

    // Completion after the eof transfer: done for exactly one cycle.
    task automatic finish_check();
        @(negedge clk);
        check("end_valid", {31'd0, valid_out}, 32'd0);
        check("end_done", {31'd0, done}, 32'd1);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_flags", {29'd0, sol, eol, eof}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_valid", {31'd0, valid_out}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {25'd0, valid_out, sol, eol, eof, busy, done, wr_err}, 32'd0);
        check({tag, "_data"}, data_out, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = {AB{1'b0}}; wr_data = 32'd0;
        start = 1'b0; abort = 1'b0; ready_in = 1'b0;

        wv[0] = '{addr: 7'd5,   data: 32'h0000_0BAD, in_stream: 1'b1, exp_err: 1'b1};
        wv[1] = '{addr: 7'd80,  data: 32'h0000_0BAD, in_stream: 1'b0, exp_err: 1'b1};
        wv[2] = '{addr: 7'd127, data: 32'h0000_0BAD, in_stream: 1'b0, exp_err: 1'b1};
        wv[3] = '{addr: 7'd79,  data: 32'd179,       in_stream: 1'b0, exp_err: 1'b0};
        wv[4] = '{addr: 7'd0,   data: 32'd100,       in_stream: 1'b0, exp_err: 1'b0};

        #23;
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;

        for (int i = 0; i < NPIX; i++) begin
            exp_mem[i] = 32'(i + 100);
            do_write(i, 32'(i + 100));
        end
        @(negedge clk);
        check("load_no_err", {31'd0, wr_err}, 32'd0);

        // Full frame, ready held high.
        stream_check(0, NPIX, 1'b0, 32'd0, 1'b1);
        finish_check();

        // Full frame with ready pattern 1,0,0,1.
        stream_check(1, NPIX, 1'b0, 32'd0, 1'b0);
        finish_check();

        // Write-port vector table.
        ready_in = 1'b0;
        for (int v = 0; v < 5; v++) begin
            if (wv[v].in_stream) begin
                @(posedge clk); #1; start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
            end
            wr_en = 1'b1; wr_addr = wv[v].addr; wr_data = wv[v].data;
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (wv[v].in_stream) abort = 1'b1;
            @(negedge clk);
            check($sformatf("wr_err_v%0d", v), {31'd0, wr_err}, {31'd0, wv[v].exp_err});
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check($sformatf("wr_err_pulse_v%0d", v), {31'd0, wr_err}, 32'd0);
            check($sformatf("wr_idle_v%0d", v), {31'd0, busy}, 32'd0);
            if (!wv[v].exp_err) exp_mem[wv[v].addr] = wv[v].data;
        end
        stream_check(0, NPIX, 1'b0, 32'd0, 1'b1);
        finish_check();

        // Same-cycle start and write to address 0.
        stream_check(0, NPIX, 1'b1, 32'h0000_DEAD, 1'b1);
        finish_check();
        exp_mem[0] = 32'd100;
        do_write(0, 32'd100);

        // Abort after the 30th transfer.
        stream_check(0, 30, 1'b0, 32'd0, 1'b0);
        abort = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_flags", {29'd0, sol, eol, eof}, 32'd0);
        check("abort_no_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_done_quiet", {31'd0, done}, 32'd0);
        end
        stream_check(0, NPIX, 1'b0, 32'd0, 1'b1);
        finish_check();

        // Reset mid-stream.
        stream_check(0, 20, 1'b0, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); @(posedge clk); #3;
        check_all_zero("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");
        stream_check(0, NPIX, 1'b0, 32'd0, 1'b1);
        finish_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
